// File: rtl/game_soc_pkg.sv
// Shared definitions for the game SoC memory master: FSM states and the
// read-latency bound supported by the read-return pipeline.
package game_soc_pkg;

  localparam int unsigned READ_LATENCY_MAX = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/game_soc_rd_pipe.sv
// Read-return pipeline: a READ_LATENCY-deep valid shift register marks the
// cycle each issued read's data is on the bus, and that word is captured.
module game_soc_rd_pipe
  import game_soc_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [DATA_W-1:0] readdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              pending
);

  // Out-of-range latencies are clamped into the supported 1..max window.
  localparam int unsigned DEPTH =
    (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
    ((READ_LATENCY < 1) ? 1 : READ_LATENCY);

  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld         <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      vld[0] <= issue;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
      rdata_valid <= vld[DEPTH-1];
      if (vld[DEPTH-1]) begin
        rdata <= readdata;
      end
    end
  end

  assign pending = |vld;

endmodule

// File: rtl/game_soc_mem_master.sv
// Burst command front end driving an Avalon-MM master port: word-addressed
// write or read bursts with wrapping addresses and fixed-latency read return.
module game_soc_mem_master
  import game_soc_pkg::*;
#(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic                wdata_valid,
  input  logic [DATA_W-1:0]   wdata,
  output logic                wdata_ready,
  output logic                rdata_valid,
  output logic [DATA_W-1:0]   rdata,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remain;
  logic              wr_xfer;
  logic              rd_issue;
  logic              last;
  logic              pipe_pending;

  assign wr_xfer  = (state == S_WRITE) && wdata_valid && !avm_waitrequest;
  assign rd_issue = (state == S_READ) && !avm_waitrequest;
  assign last     = (remain == LEN_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      addr   <= '0;
      remain <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr   <= cmd_addr;
            remain <= cmd_len;
            if (cmd_len == '0)   state <= S_DONE;
            else if (cmd_write)  state <= S_WRITE;
            else                 state <= S_READ;
          end
        end
        S_WRITE: begin
          if (wr_xfer) begin
            addr   <= addr + 1'b1;
            remain <= remain - 1'b1;
            if (last) state <= S_DONE;
          end
        end
        S_READ: begin
          if (rd_issue) begin
            addr   <= addr + 1'b1;
            remain <= remain - 1'b1;
            if (last) state <= S_DRAIN;
          end
        end
        // The final return is the one that leaves nothing behind it in the pipe.
        S_DRAIN: begin
          if (rdata_valid && !pipe_pending) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state == S_IDLE);
  assign done           = (state == S_DONE);
  assign wdata_ready    = (state == S_WRITE) && !avm_waitrequest;
  assign avm_write      = (state == S_WRITE) && wdata_valid;
  assign avm_read       = (state == S_READ);
  assign avm_chipselect = avm_write || avm_read;
  assign avm_address    = addr;
  assign avm_byteenable = '1;
  assign avm_writedata  = (state == S_WRITE) ? wdata : '0;

  game_soc_rd_pipe #(
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .issue      (rd_issue),
    .readdata   (avm_readdata),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .pending    (pipe_pending)
  );

endmodule

// File: tb/tb_game_soc_mem_master.sv
// Directed bench for game_soc_mem_master with a transaction-level model and a
// small Avalon slave memory kept inside the bench.
module tb_game_soc_mem_master;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [2:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        wdata_ready;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        done;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  game_soc_mem_master #(
    .ADDR_W      (2),
    .DATA_W      (32),
    .READ_LATENCY(LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wdata_valid    (wdata_valid),
    .wdata          (wdata),
    .wdata_ready    (wdata_ready),
    .rdata_valid    (rdata_valid),
    .rdata          (rdata),
    .done           (done),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  typedef struct { int addr; bit we; } tx_t;
  typedef struct { logic [31:0] d; int c; } rx_t;

  tx_t         txq[$];
  rx_t         expq[$];
  logic [31:0] wq[$];
  logic [31:0] mem[4];
  logic [31:0] rd_sched[8];
  bit          wait_pat[16];
  bit          gap_pat[16];

  int cyc = 0;
  int acc_cyc = -1000;
  int acc_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_done_cyc = -1;
  bit busy = 1'b0;
  int cnt_cs, cnt_xfer, cnt_rv;
  int addr_log[$];
  logic [31:0] rv_log[$];
  int acc_log[$];
  int rel;
  bit has_tx, we_h, cs_exp, rv_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave/source drive for this cycle, then check DUT against the model.
  always @(negedge clk) begin
    rel = cyc - acc_cyc;
    avm_waitrequest = (rel >= 0 && rel < 16) ? wait_pat[rel] : 1'b0;
    wdata_valid = (wq.size() > 0) && !((rel >= 0 && rel < 16) ? gap_pat[rel] : 1'b0);
    wdata = (wq.size() > 0) ? wq[0] : 32'h0;
    avm_readdata = rd_sched[cyc % 8];
    #1;
    if (reset) begin
      txq.delete();
      expq.delete();
      busy = 1'b0;
      exp_done_cyc = -1;
      for (int i = 0; i < 8; i++) rd_sched[i] = 32'hDEAD_0000 + i;
    end else begin
      has_tx = txq.size() > 0;
      we_h   = has_tx && txq[0].we;
      cs_exp = has_tx && (!txq[0].we || wdata_valid);
      chk("cmd_ready", cmd_ready, !busy);
      chk("chipselect", avm_chipselect, cs_exp);
      chk("avm_write", avm_write, cs_exp && we_h);
      chk("avm_read", avm_read, cs_exp && !we_h);
      chk("wdata_ready", wdata_ready, we_h && !avm_waitrequest);
      chk("done", done, cyc == exp_done_cyc);
      if (avm_chipselect) cnt_cs++;
      if (cs_exp) begin
        chk("address", avm_address, txq[0].addr);
        chk("byteenable", avm_byteenable, 4'hF);
        if (we_h) chk("writedata", avm_writedata, wq[0]);
        if (!avm_waitrequest) begin
          cnt_xfer++;
          addr_log.push_back(txq[0].addr);
          if (we_h) begin
            mem[txq[0].addr] = wq.pop_front();
          end else begin
            rd_sched[(cyc + LAT) % 8] = mem[txq[0].addr];
            expq.push_back('{mem[txq[0].addr], cyc + LAT + 1});
          end
          void'(txq.pop_front());
          if (we_h && txq.size() == 0) exp_done_cyc = cyc + 1;
        end
      end
      rv_exp = (expq.size() > 0) && (expq[0].c == cyc);
      chk("rdata_valid", rdata_valid, rv_exp);
      if (rdata_valid) begin
        cnt_rv++;
        rv_log.push_back(rdata);
      end
      if (rv_exp) begin
        chk("rdata", rdata, expq[0].d);
        void'(expq.pop_front());
        if (expq.size() == 0 && txq.size() == 0) exp_done_cyc = cyc + 1;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc == exp_done_cyc) busy = 1'b0;
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        acc_cyc = cyc;
        acc_log.push_back(cyc);
        busy = 1'b1;
        for (int i = 0; i < int'(cmd_len); i++) txq.push_back('{(int'(cmd_addr) + i) % 4, cmd_write});
        if (cmd_len == 0) exp_done_cyc = cyc + 1;
      end
    end
  end

  task automatic clear_stats();
    cnt_cs = 0;
    cnt_xfer = 0;
    cnt_rv = 0;
    addr_log.delete();
    rv_log.delete();
    acc_log.delete();
  endtask

  task automatic start_cmd(input bit we, input int a, input int len);
    int n0;
    int g;
    n0 = acc_cnt;
    clear_stats();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = we;
    cmd_addr  = 2'(a);
    cmd_len   = 3'(len);
    @(negedge clk);
    g = 0;
    while (acc_cnt == n0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b0;
    chk("accepted", acc_cnt - n0, 1);
  endtask

  task automatic run_cmd(input bit we, input int a, input int len, output int lat);
    int d0;
    int g;
    d0 = done_cnt;
    start_cmd(we, a, len);
    g = 0;
    while (done_cnt == d0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    #2;
    chk("done_seen", done_cnt - d0, 1);
    lat = done_cyc - acc_cyc;
  endtask

  task automatic clear_pats();
    for (int i = 0; i < 16; i++) begin
      wait_pat[i] = 1'b0;
      gap_pat[i]  = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int rv0;
    int g;
    clear_pats();
    for (int i = 0; i < 4; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cs_rd_wr", {avm_chipselect, avm_read, avm_write}, 0);
    chk("rst_address", avm_address, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    reset = 1'b0;

    // Write burst 0..3 with data offered continuously (also offered while idle).
    wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    repeat (2) @(negedge clk);
    run_cmd(1'b1, 0, 4, lat);
    chk("w4_addrs", {addr_log[0][7:0], addr_log[1][7:0], addr_log[2][7:0], addr_log[3][7:0]}, 32'h00010203);
    chk("w4_cs_cycles", cnt_cs, 4);
    chk("w4_done_lat", lat, 5);

    // Wrapping read 2,3,0.
    run_cmd(1'b0, 2, 3, lat);
    chk("r3_addrs", {addr_log[0][7:0], addr_log[1][7:0], addr_log[2][7:0]}, 32'h00020300);
    chk("r3_count", cnt_rv, 3);
    chk("r3_data0", rv_log[0], 32'h33333333);
    chk("r3_data1", rv_log[1], 32'h44444444);
    chk("r3_data2", rv_log[2], 32'h11111111);
    chk("r3_done_lat", lat, 6);

    // Read with waitrequest held for three cycles at the first issue.
    for (int i = 1; i <= 3; i++) wait_pat[i] = 1'b1;
    run_cmd(1'b0, 0, 2, lat);
    clear_pats();
    chk("rw_cs_cycles", cnt_cs, 5);
    chk("rw_xfers", cnt_xfer, 2);
    chk("rw_rv_count", cnt_rv, 2);
    chk("rw_data1", rv_log[1], 32'h22222222);
    chk("rw_done_lat", lat, 8);

    // Write with a two-cycle gap in wdata_valid.
    gap_pat[2] = 1'b1;
    gap_pat[3] = 1'b1;
    wq = '{32'hAAAA0001, 32'hAAAA0002};
    run_cmd(1'b1, 1, 2, lat);
    clear_pats();
    chk("wg_writes", cnt_cs, 2);
    chk("wg_addrs", {addr_log[0][7:0], addr_log[1][7:0]}, 32'h0102);
    chk("wg_done_lat", lat, 5);

    // Zero-length command.
    run_cmd(1'b1, 2, 0, lat);
    chk("z_cs_cycles", cnt_cs, 0);
    chk("z_done_lat", lat, 1);

    // Write wrapping 3 -> 0, then full read from 1.
    wq = '{32'hBBBB0001, 32'hBBBB0002};
    run_cmd(1'b1, 3, 2, lat);
    chk("ww_addrs", {addr_log[0][7:0], addr_log[1][7:0]}, 32'h0300);
    run_cmd(1'b0, 1, 4, lat);
    chk("r4_data0", rv_log[0], 32'hAAAA0001);
    chk("r4_data1", rv_log[1], 32'hAAAA0002);
    chk("r4_data2", rv_log[2], 32'hBBBB0001);
    chk("r4_data3", rv_log[3], 32'hBBBB0002);
    chk("r4_done_lat", lat, 7);

    // Back-to-back zero-length commands: one idle cycle between accepts.
    clear_stats();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_len   = '0;
    g = 0;
    while (acc_log.size() < 2 && g < 20) begin
      @(negedge clk);
      g++;
    end
    #2;
    cmd_valid = 1'b0;
    chk("b2b_accepts", acc_log.size(), 2);
    if (acc_log.size() >= 2) chk("b2b_spacing", acc_log[1] - acc_log[0], 2);
    repeat (3) @(negedge clk);

    // Reset in the middle of a read burst.
    start_cmd(1'b0, 0, 4);
    g = 0;
    while (cnt_xfer < 2 && g < 20) begin
      @(negedge clk);
      g++;
    end
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("mr_cs_rd_wr", {avm_chipselect, avm_read, avm_write}, 0);
    chk("mr_rdata_valid", rdata_valid, 0);
    chk("mr_address", avm_address, 0);
    chk("mr_done", done, 0);
    reset = 1'b0;
    rv0 = cnt_rv;
    repeat (6) @(negedge clk);
    #2;
    chk("mr_no_more_rv", cnt_rv - rv0, 0);
    chk("mr_cmd_ready", cmd_ready, 1);

    // Recovery after reset.
    run_cmd(1'b0, 3, 1, lat);
    chk("rec_data", rv_log[0], 32'hBBBB0001);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
